debouncer_multi: RTL and testbench

- Parametrised N-channel switch/button debouncer for board-level inputs.
- Each channel: 2-FF synchroniser plus a four-state stability FSM.
- A shared prescaler sets the stability window in ticks; each channel holds its own tick counter.
- Sits between raw pad inputs and user logic; successor to the single-channel 1 ms debouncer, with width, window and reset value all parametrised.

---
 rtl/debouncer_pkg.sv | 21 ++
 rtl/debouncer_multi_channel.sv | 130 +++++++++++++
 rtl/debouncer_multi.sv | 70 +++++++
 tb/tb_debouncer_multi.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/debouncer_pkg.sv
// Shared definitions for the multi-channel debouncer.
//   db_state_t : 2-bit stability FSM encoding
//                (STABLE0=00, PEND1=01, STABLE1=11, PEND0=10)
//   width_of() : $clog2-based counter width, never below 1 bit
package debouncer_pkg;

  typedef enum logic [1:0] {
    STABLE0 = 2'b00,
    PEND1   = 2'b01,
    STABLE1 = 2'b11,
    PEND0   = 2'b10
  } db_state_t;

  // Bits needed to hold 0..n-1, with a floor of one bit so that n == 1
  // still yields a legal vector.
  function automatic int width_of(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/debouncer_multi_channel.sv
// One debouncer channel: 2-FF synchroniser, four-state stability FSM,
// per-channel tick counter and optional edge pulses.
// Optional feature macro: DEBOUNCE_EDGE_EN (rise/fall pulses; tied 0 otherwise).
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-high reset
//   tick  in   shared prescaler tick (one-cycle strobe)
//   raw   in   asynchronous switch level
//   level out  debounced level (registered)
//   rise  out  one-cycle pulse on debounced 0->1
//   fall  out  one-cycle pulse on debounced 1->0
//   pend  out  high while the FSM is in PEND0/PEND1 (registered)
module debounce_channel
  import debouncer_pkg::*;
#(
  parameter int   STABLE_TICKS = 100,
  parameter logic INIT_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic pend
);

  localparam int             CNT_W    = width_of(STABLE_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic             sync_p0;
  logic             sync_p1;
  db_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             window_done;

  // The last tick of the window: the FSM commits on this cycle unless the
  // synchronised input reverts at the same time (revert has priority).
  assign window_done = tick && (cnt == CNT_LAST);

  // ---- stage p0/p1: synchroniser, preset to INIT_VAL so release is quiet
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= INIT_VAL;
      sync_p1 <= INIT_VAL;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // ---- stability FSM on sync_p1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT_VAL ? STABLE1 : STABLE0;
      cnt   <= '0;
      level <= INIT_VAL;
      pend  <= 1'b0;
    end else begin
      case (state)
        STABLE0: begin
          cnt <= '0;
          if (sync_p1) begin
            state <= PEND1;
            pend  <= 1'b1;
          end
        end
        PEND1: begin
          if (!sync_p1) begin
            state <= STABLE0;
            cnt   <= '0;
            pend  <= 1'b0;
          end else if (window_done) begin
            state <= STABLE1;
            level <= 1'b1;
            cnt   <= '0;
            pend  <= 1'b0;
          end else if (tick) begin
            cnt <= cnt + 1'b1;
          end
        end
        STABLE1: begin
          cnt <= '0;
          if (!sync_p1) begin
            state <= PEND0;
            pend  <= 1'b1;
          end
        end
        PEND0: begin
          if (sync_p1) begin
            state <= STABLE1;
            cnt   <= '0;
            pend  <= 1'b0;
          end else if (window_done) begin
            state <= STABLE0;
            level <= 1'b0;
            cnt   <= '0;
            pend  <= 1'b0;
          end else if (tick) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= STABLE0;
          cnt   <= '0;
          level <= 1'b0;
          pend  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DEBOUNCE_EDGE_EN
  // ---- edge pulses, registered on the same edge that updates level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= (state == PEND1) && sync_p1 && window_done;
      fall <= (state == PEND0) && !sync_p1 && window_done;
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/debouncer_multi.sv
// N-channel switch/button debouncer. A free-running shared prescaler
// produces a tick every TICK_DIV cycles; each channel requires its
// synchronised input to hold for STABLE_TICKS ticks before following it.
// Optional feature macro: DEBOUNCE_EDGE_EN (rise/fall pulses; tied 0 otherwise).
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-high reset
//   db_inp  in   [N_CH] raw asynchronous switch inputs
//   db_out  out  [N_CH] debounced levels (registered)
//   rise    out  [N_CH] one-cycle pulse on debounced 0->1
//   fall    out  [N_CH] one-cycle pulse on debounced 1->0
//   pend    out  [N_CH] high while a channel is pending (registered)
module debouncer_multi
  import debouncer_pkg::*;
#(
  parameter int              N_CH         = 4,
  parameter int              TICK_DIV     = 1000,
  parameter int              STABLE_TICKS = 100,
  parameter logic [N_CH-1:0] INIT_VAL     = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] db_inp,
  output logic [N_CH-1:0] db_out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] pend
);

  logic tick;

  // ---- shared prescaler
  generate
    if (TICK_DIV == 1) begin : g_no_pre
      assign tick = 1'b1;
    end else begin : g_pre
      localparam int             PRE_W    = width_of(TICK_DIV);
      localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
      logic [PRE_W-1:0] pre_cnt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)                    pre_cnt <= '0;
        else if (pre_cnt == PRE_LAST) pre_cnt <= '0;
        else                        pre_cnt <= pre_cnt + 1'b1;
      end

      assign tick = (pre_cnt == PRE_LAST);
    end
  endgenerate

  // ---- independent channels
  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_channel #(
        .STABLE_TICKS (STABLE_TICKS),
        .INIT_VAL     (INIT_VAL[i])
      ) u_ch (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .raw   (db_inp[i]),
        .level (db_out[i]),
        .rise  (rise[i]),
        .fall  (fall[i]),
        .pend  (pend[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_debouncer_multi.sv
// Bench for debouncer_multi: two instances (A: TICK_DIV=1, STABLE_TICKS=4,
// INIT=10; B: TICK_DIV=5, STABLE_TICKS=3, INIT=01) driven with directed
// and random input sequences and compared every cycle to a reference model.
module tb_debouncer_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] inp_a = 2'b10;
  logic [1:0] inp_b = 2'b01;
  logic [1:0] out_a, rise_a, fall_a, pend_a;
  logic [1:0] out_b, rise_b, fall_b, pend_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  debouncer_multi #(
    .N_CH(2), .TICK_DIV(1), .STABLE_TICKS(4), .INIT_VAL(2'b10)
  ) dut_a (
    .clk(clk), .rst(rst), .db_inp(inp_a),
    .db_out(out_a), .rise(rise_a), .fall(fall_a), .pend(pend_a)
  );

  debouncer_multi #(
    .N_CH(2), .TICK_DIV(5), .STABLE_TICKS(3), .INIT_VAL(2'b01)
  ) dut_b (
    .clk(clk), .rst(rst), .db_inp(inp_b),
    .db_out(out_b), .rise(rise_b), .fall(fall_b), .pend(pend_b)
  );

  // ---------------- reference model ----------------
  // Per channel: the synchronised view is the input as driven two edges
  // earlier. Once it differs from the output (noticed on one edge), the
  // output follows after that many ticks have elapsed with the view held
  // steady; any revert cancels the pending change.
  int         td[2]   = '{1, 5};
  int         st[2]   = '{4, 3};
  logic [1:0] initv[2] = '{2'b10, 2'b01};

  logic [1:0] m_out[2], m_pend[2], m_rise[2], m_fall[2];
  logic [1:0] m_d1[2], m_d2[2];
  int         m_ticks[2][2];
  int         edge_no;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_out[d]  = initv[d];
      m_d1[d]   = initv[d];
      m_d2[d]   = initv[d];
      m_pend[d] = 2'b00;
      m_rise[d] = 2'b00;
      m_fall[d] = 2'b00;
      for (int c = 0; c < 2; c++) m_ticks[d][c] = 0;
    end
    edge_no = 0;
  endtask

  task automatic model_edge(input logic [1:0] ia, input logic [1:0] ib);
    logic [1:0] inp[2];
    logic       s, tk;
    inp[0] = ia;
    inp[1] = ib;
    for (int d = 0; d < 2; d++) begin
      tk = ((edge_no % td[d]) == td[d] - 1);
      m_rise[d] = 2'b00;
      m_fall[d] = 2'b00;
      for (int c = 0; c < 2; c++) begin
        s = m_d2[d][c];
        if (!m_pend[d][c]) begin
          if (s != m_out[d][c]) begin
            m_pend[d][c]  = 1'b1;
            m_ticks[d][c] = 0;
          end
        end else if (s == m_out[d][c]) begin
          m_pend[d][c] = 1'b0;
        end else if (tk) begin
          m_ticks[d][c]++;
          if (m_ticks[d][c] == st[d]) begin
            m_out[d][c]  = s;
            m_pend[d][c] = 1'b0;
`ifdef DEBOUNCE_EDGE_EN
            if (s) m_rise[d][c] = 1'b1;
            else   m_fall[d][c] = 1'b1;
`endif
          end
        end
      end
      m_d2[d] = m_d1[d];
      m_d1[d] = inp[d];
    end
    edge_no++;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s at %0t: observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("a_db_out", out_a,  m_out[0]);
    check("a_pend",   pend_a, m_pend[0]);
    check("a_rise",   rise_a, m_rise[0]);
    check("a_fall",   fall_a, m_fall[0]);
    check("b_db_out", out_b,  m_out[1]);
    check("b_pend",   pend_b, m_pend[1]);
    check("b_rise",   rise_b, m_rise[1]);
    check("b_fall",   fall_b, m_fall[1]);
  endtask

  // Advance n clock edges, updating the model and checking #1 after each.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge(inp_a, inp_b);
      #1;
      compare_all();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int idx;

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    model_reset();
    #1 compare_all();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    rst = 1'b0;
    model_reset();

    // Quiet release: outputs hold, no pulses.
    cyc(6);

    // Clean step on A ch0.
    inp_a = 2'b11;
    cyc(10);

    // Return to 0, then a 3-cycle glitch that must be rejected.
    inp_a = 2'b10;
    cyc(10);
    inp_a = 2'b11;
    cyc(3);
    inp_a = 2'b10;
    cyc(10);

    // Simultaneous change, ch1 bouncing once.
    inp_a = 2'b00;
    cyc(10);
    inp_a = 2'b11;
    cyc(4);
    inp_a = 2'b01;
    cyc(1);
    inp_a = 2'b11;
    cyc(12);

    // Prescaled instance: clean steps on both channels.
    inp_b = 2'b10;
    cyc(30);
    inp_b = 2'b01;
    cyc(30);

    // Random traffic on both instances.
    repeat (600) begin
      if ($urandom_range(0, 9) == 0) begin
        idx = $urandom_range(0, 1);
        inp_a[idx] = ~inp_a[idx];
      end
      if ($urandom_range(0, 13) == 0) begin
        idx = $urandom_range(0, 1);
        inp_b[idx] = ~inp_b[idx];
      end
      cyc(1);
    end

    // Settle, then start a change on B and reset in the middle of its window.
    inp_a = 2'b10;
    inp_b = 2'b01;
    cyc(40);
    inp_b = 2'b10;
    cyc(8);
    check("b_pend_before_rst", pend_b, 2'b11);
    #2 rst = 1'b1;
    model_reset();
    #1 compare_all();
    inp_b = 2'b01;
    @(negedge clk);
    compare_all();
    rst = 1'b0;
    model_reset();
    cyc(25);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
